// File: rtl/sfa_switch_sequencer.sv
// Command-driven routing sequencer for the 2x2 tile switch fabric: applies one
// command's selects, gates the datapath for LEN beats, then returns a status word.
module sfa_switch_sequencer #(
   parameter int unsigned SETTLE  = 2,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        ACLK,
   input  logic        ARESETN,
   output logic        sCMD_tready,
   input  logic        sCMD_tvalid,
   input  logic [31:0] sCMD_tdata,
   input  logic        mRet_tready,
   output logic        mRet_tvalid,
   output logic [31:0] mRet_tdata,
   input  logic        obs_tvalid,
   input  logic        obs_tready,
   output logic [1:0]  IN1CONF,
   output logic [1:0]  IN2CONF,
   output logic        MUXCONF,
   output logic [1:0]  OUTCONF,
   output logic        GATE
);

   localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_RUN, S_RESP} state_t;

   state_t        state, state_n;
   logic          cmd_rdy_n, ret_vld_n, gate_n, mux_n, err, err_n;
   logic [1:0]    in1_n, in2_n, out_n;
   logic [31:0]   ret_data_n;
   logic [15:0]   len, len_n, cnt, cnt_n, cnt_inc;
   logic [TW-1:0] tmo, tmo_n;
   logic [SW-1:0] stl, stl_n;
   logic          beat;
   logic          unused_cmd_bits;

   assign beat            = obs_tvalid & obs_tready;
   assign cnt_inc         = cnt + 16'd1;
   assign unused_cmd_bits = ^sCMD_tdata[15:7];

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state       <= S_IDLE;
         sCMD_tready <= 1'b0;
         mRet_tvalid <= 1'b0;
         mRet_tdata  <= '0;
         IN1CONF     <= '0;
         IN2CONF     <= '0;
         MUXCONF     <= 1'b0;
         OUTCONF     <= '0;
         GATE        <= 1'b0;
         len         <= '0;
         cnt         <= '0;
         tmo         <= '0;
         stl         <= '0;
         err         <= 1'b0;
      end else begin
         state       <= state_n;
         sCMD_tready <= cmd_rdy_n;
         mRet_tvalid <= ret_vld_n;
         mRet_tdata  <= ret_data_n;
         IN1CONF     <= in1_n;
         IN2CONF     <= in2_n;
         MUXCONF     <= mux_n;
         OUTCONF     <= out_n;
         GATE        <= gate_n;
         len         <= len_n;
         cnt         <= cnt_n;
         tmo         <= tmo_n;
         stl         <= stl_n;
         err         <= err_n;
      end
   end

   always_comb begin
      state_n    = state;
      cmd_rdy_n  = sCMD_tready;
      ret_vld_n  = mRet_tvalid;
      ret_data_n = mRet_tdata;
      in1_n      = IN1CONF;
      in2_n      = IN2CONF;
      mux_n      = MUXCONF;
      out_n      = OUTCONF;
      gate_n     = GATE;
      len_n      = len;
      cnt_n      = cnt;
      tmo_n      = tmo;
      stl_n      = stl;
      err_n      = err;
      case (state)
         S_IDLE: begin
            cmd_rdy_n = 1'b1;
            if (sCMD_tvalid && sCMD_tready) begin
               in1_n     = sCMD_tdata[1:0];
               in2_n     = sCMD_tdata[3:2];
               mux_n     = sCMD_tdata[4];
               out_n     = sCMD_tdata[6:5];
               len_n     = sCMD_tdata[31:16];
               cmd_rdy_n = 1'b0;
               gate_n    = 1'b0;
               stl_n     = '0;
               state_n   = S_APPLY;
            end
         end
         S_APPLY: begin
            if (stl == SW'(SETTLE - 1)) begin
               stl_n = '0;
               cnt_n = '0;
               tmo_n = '0;
               err_n = 1'b0;
               if (len == 16'd0) begin
                  state_n = S_RESP;
               end else begin
                  gate_n  = 1'b1;
                  state_n = S_RUN;
               end
            end else begin
               stl_n = stl + 1'b1;
            end
         end
         S_RUN: begin
            // a beat is checked before the timeout so a last beat on the boundary cycle wins
            if (beat) begin
               cnt_n = cnt_inc;
               tmo_n = '0;
               if (cnt_inc == len) begin
                  gate_n  = 1'b0;
                  err_n   = 1'b0;
                  state_n = S_RESP;
               end
            end else if (tmo == TW'(TIMEOUT - 1)) begin
               gate_n  = 1'b0;
               err_n   = 1'b1;
               state_n = S_RESP;
            end else begin
               tmo_n = tmo + 1'b1;
            end
         end
         S_RESP: begin
            if (!mRet_tvalid) begin
               ret_vld_n  = 1'b1;
               ret_data_n = {err, 15'd0, cnt};
            end else if (mRet_tready) begin
               ret_vld_n = 1'b0;
               cmd_rdy_n = 1'b1;
               state_n   = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_sfa_switch_sequencer.sv
// Directed bench for sfa_switch_sequencer (SETTLE=2, TIMEOUT=16); stimulus is
// driven and outputs are sampled on the falling clock edge.
module tb_sfa_switch_sequencer;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic        sCMD_tready;
   logic        sCMD_tvalid = 1'b0;
   logic [31:0] sCMD_tdata = '0;
   logic        mRet_tready = 1'b0;
   logic        mRet_tvalid;
   logic [31:0] mRet_tdata;
   logic        obs_tvalid = 1'b0;
   logic        obs_tready = 1'b0;
   logic [1:0]  IN1CONF, IN2CONF, OUTCONF;
   logic        MUXCONF, GATE;
   logic [6:0]  conf;

   int n_cmp = 0;
   int n_err = 0;

   assign conf = {IN1CONF, IN2CONF, MUXCONF, OUTCONF};

   sfa_switch_sequencer #(.SETTLE(2), .TIMEOUT(16)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .sCMD_tready(sCMD_tready), .sCMD_tvalid(sCMD_tvalid), .sCMD_tdata(sCMD_tdata),
      .mRet_tready(mRet_tready), .mRet_tvalid(mRet_tvalid), .mRet_tdata(mRet_tdata),
      .obs_tvalid(obs_tvalid), .obs_tready(obs_tready),
      .IN1CONF(IN1CONF), .IN2CONF(IN2CONF), .MUXCONF(MUXCONF), .OUTCONF(OUTCONF),
      .GATE(GATE)
   );

   always #5 ACLK = ~ACLK;

   task automatic tick(input int n);
      repeat (n) @(negedge ACLK);
   endtask

   task automatic test_reset;
      tick(2);
      n_cmp++; if ({sCMD_tready, mRet_tvalid, GATE, conf} !== 10'd0) begin n_err++;
         $display("FAIL reset_outputs: got %b want 0", {sCMD_tready, mRet_tvalid, GATE, conf}); end
      n_cmp++; if (mRet_tdata !== 32'd0) begin n_err++;
         $display("FAIL reset_tdata: got %h want 00000000", mRet_tdata); end
      ARESETN = 1'b1;
      tick(1);
      n_cmp++; if (sCMD_tready !== 1'b1) begin n_err++;
         $display("FAIL reset_ready_after_release: got %b want 1", sCMD_tready); end
   endtask

   task automatic test_basic;
      sCMD_tvalid = 1'b1; sCMD_tdata = 32'h0003_0059;
      tick(1);
      sCMD_tvalid = 1'b0; obs_tvalid = 1'b1; obs_tready = 1'b1;
      n_cmp++; if (conf !== {2'd1, 2'd2, 1'b1, 2'd2}) begin n_err++;
         $display("FAIL basic_conf: got %b want 0110110", conf); end
      n_cmp++; if ({sCMD_tready, GATE} !== 2'b00) begin n_err++;
         $display("FAIL basic_apply_ready_gate: got %b want 00", {sCMD_tready, GATE}); end
      tick(1);
      n_cmp++; if (GATE !== 1'b0) begin n_err++;
         $display("FAIL basic_gate_settle: got %b want 0", GATE); end
      for (int i = 0; i < 3; i++) begin
         tick(1);
         n_cmp++; if (GATE !== 1'b1) begin n_err++;
            $display("FAIL basic_gate_run%0d: got %b want 1", i, GATE); end
      end
      tick(1);
      obs_tvalid = 1'b0; obs_tready = 1'b0;
      n_cmp++; if ({GATE, mRet_tvalid} !== 2'b00) begin n_err++;
         $display("FAIL basic_gate_off: got %b want 00", {GATE, mRet_tvalid}); end
      tick(1);
      n_cmp++; if ({mRet_tvalid, mRet_tdata} !== {1'b1, 32'h0000_0003}) begin n_err++;
         $display("FAIL basic_ret: got %b/%h want 1/00000003", mRet_tvalid, mRet_tdata); end
      mRet_tready = 1'b1;
      tick(1);
      mRet_tready = 1'b0;
      n_cmp++; if ({mRet_tvalid, sCMD_tready} !== 2'b01) begin n_err++;
         $display("FAIL basic_after_handshake: got %b want 01", {mRet_tvalid, sCMD_tready}); end
   endtask

   task automatic test_len0;
      logic gate_seen;
      gate_seen = 1'b0;
      sCMD_tvalid = 1'b1; sCMD_tdata = 32'h0000_002E;
      obs_tvalid = 1'b1; obs_tready = 1'b1;
      tick(1);
      sCMD_tvalid = 1'b0;
      n_cmp++; if (conf !== {2'd2, 2'd3, 1'b0, 2'd1}) begin n_err++;
         $display("FAIL len0_conf: got %b want 1011001", conf); end
      gate_seen = gate_seen | GATE;
      for (int i = 0; i < 2; i++) begin
         tick(1);
         gate_seen = gate_seen | GATE;
         n_cmp++; if (mRet_tvalid !== 1'b0) begin n_err++;
            $display("FAIL len0_early_ret%0d: got %b want 0", i, mRet_tvalid); end
      end
      tick(1);
      gate_seen = gate_seen | GATE;
      obs_tvalid = 1'b0; obs_tready = 1'b0;
      n_cmp++; if ({mRet_tvalid, mRet_tdata} !== {1'b1, 32'h0}) begin n_err++;
         $display("FAIL len0_ret: got %b/%h want 1/00000000", mRet_tvalid, mRet_tdata); end
      n_cmp++; if (gate_seen !== 1'b0) begin n_err++;
         $display("FAIL len0_gate_never: got %b want 0", gate_seen); end
      mRet_tready = 1'b1;
      tick(1);
      mRet_tready = 1'b0;
   endtask

   task automatic test_timeout;
      sCMD_tvalid = 1'b1; sCMD_tdata = 32'h0005_0000;
      obs_tready = 1'b1;
      tick(1);
      sCMD_tvalid = 1'b0;
      n_cmp++; if (conf !== 7'd0) begin n_err++;
         $display("FAIL timeout_conf: got %b want 0000000", conf); end
      tick(2);
      obs_tvalid = 1'b1;
      tick(2);
      obs_tvalid = 1'b0;
      tick(15);
      n_cmp++; if (GATE !== 1'b1) begin n_err++;
         $display("FAIL timeout_gate_before_abort: got %b want 1", GATE); end
      tick(1);
      n_cmp++; if ({GATE, mRet_tvalid} !== 2'b00) begin n_err++;
         $display("FAIL timeout_gate_abort: got %b want 00", {GATE, mRet_tvalid}); end
      tick(1);
      n_cmp++; if ({mRet_tvalid, mRet_tdata} !== {1'b1, 32'h8000_0002}) begin n_err++;
         $display("FAIL timeout_ret: got %b/%h want 1/80000002", mRet_tvalid, mRet_tdata); end
      obs_tready = 1'b0;
      mRet_tready = 1'b1;
      tick(1);
      mRet_tready = 1'b0;
   endtask

   task automatic test_back_to_back;
      sCMD_tvalid = 1'b1; sCMD_tdata = 32'h0001_0041;
      tick(1);
      sCMD_tvalid = 1'b0;
      tick(2);
      obs_tvalid = 1'b1; obs_tready = 1'b1;
      tick(1);
      obs_tvalid = 1'b0; obs_tready = 1'b0;
      tick(1);
      sCMD_tvalid = 1'b1; sCMD_tdata = 32'h0000_0035;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         n_cmp++; if ({mRet_tvalid, mRet_tdata, sCMD_tready} !== {1'b1, 32'h0000_0001, 1'b0}) begin n_err++;
            $display("FAIL b2b_stall%0d: got %b/%h/%b want 1/00000001/0", i, mRet_tvalid, mRet_tdata, sCMD_tready); end
      end
      n_cmp++; if (conf !== {2'd1, 2'd0, 1'b0, 2'd2}) begin n_err++;
         $display("FAIL b2b_conf_hold: got %b want 0100010", conf); end
      mRet_tready = 1'b1;
      tick(1);
      mRet_tready = 1'b0;
      n_cmp++; if ({mRet_tvalid, sCMD_tready} !== 2'b01) begin n_err++;
         $display("FAIL b2b_ready_return: got %b want 01", {mRet_tvalid, sCMD_tready}); end
      tick(1);
      sCMD_tvalid = 1'b0;
      n_cmp++; if ({sCMD_tready, conf} !== {1'b0, 2'd1, 2'd1, 1'b1, 2'd1}) begin n_err++;
         $display("FAIL b2b_second_accept: got %b want 00101101", {sCMD_tready, conf}); end
      tick(3);
      n_cmp++; if ({mRet_tvalid, mRet_tdata} !== {1'b1, 32'h0}) begin n_err++;
         $display("FAIL b2b_second_ret: got %b/%h want 1/00000000", mRet_tvalid, mRet_tdata); end
      mRet_tready = 1'b1;
      tick(1);
      mRet_tready = 1'b0;
   endtask

   task automatic test_boundary;
      obs_tvalid = 1'b1; obs_tready = 1'b1;
      tick(3);
      obs_tvalid = 1'b0;
      sCMD_tvalid = 1'b1; sCMD_tdata = 32'h0004_0000;
      tick(1);
      sCMD_tvalid = 1'b0;
      tick(2);
      obs_tvalid = 1'b1;
      tick(3);
      obs_tvalid = 1'b0;
      tick(15);
      n_cmp++; if (GATE !== 1'b1) begin n_err++;
         $display("FAIL boundary_gate_before: got %b want 1", GATE); end
      obs_tvalid = 1'b1;
      tick(1);
      obs_tvalid = 1'b0; obs_tready = 1'b0;
      n_cmp++; if (GATE !== 1'b0) begin n_err++;
         $display("FAIL boundary_gate_off: got %b want 0", GATE); end
      tick(1);
      n_cmp++; if ({mRet_tvalid, mRet_tdata} !== {1'b1, 32'h0000_0004}) begin n_err++;
         $display("FAIL boundary_ret: got %b/%h want 1/00000004", mRet_tvalid, mRet_tdata); end
      mRet_tready = 1'b1;
      tick(1);
      mRet_tready = 1'b0;
   endtask

   task automatic test_reset_midrun;
      sCMD_tvalid = 1'b1; sCMD_tdata = 32'h0009_007F;
      obs_tready = 1'b1;
      tick(1);
      sCMD_tvalid = 1'b0;
      tick(2);
      obs_tvalid = 1'b1;
      n_cmp++; if ({GATE, conf} !== 8'hFF) begin n_err++;
         $display("FAIL midrun_running: got %b want 11111111", {GATE, conf}); end
      tick(2);
      #2 ARESETN = 1'b0;
      #1;
      n_cmp++; if ({GATE, conf, mRet_tvalid, sCMD_tready} !== 10'd0) begin n_err++;
         $display("FAIL midrun_async_clear: got %b want 0", {GATE, conf, mRet_tvalid, sCMD_tready}); end
      tick(2);
      ARESETN = 1'b1;
      tick(1);
      obs_tvalid = 1'b0; obs_tready = 1'b0;
      n_cmp++; if ({sCMD_tready, GATE, mRet_tvalid} !== 3'b100) begin n_err++;
         $display("FAIL midrun_idle_after_release: got %b want 100", {sCMD_tready, GATE, mRet_tvalid}); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len0();
      test_timeout();
      test_back_to_back();
      test_boundary();
      test_reset_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
